// File: rtl/regfile_pkg.sv
// Shared register-file types: data/address widths and the write-back request record.
// Used by the write-back initiator, the register file and decode.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot register mask for a destination address.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load write-backs with occupancy and a per-register
// pending mask, used to hold loads while the ALU owns the write port.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [REG_ADDR_W-1:0]   push_addr,
    input  logic [XLEN-1:0]         push_data,
    input  logic                    pop,
    output logic [REG_ADDR_W-1:0]   head_addr,
    output logic [XLEN-1:0]         head_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic [NUM_REGS-1:0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    wb_req_t          mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [NUM_REGS-1:0] pending_s;

    assign push_ok_s = push && (count_r < DEPTH_C);
    assign pop_ok_s  = pop && (count_r != {(PTR_W+1){1'b0}});

    // Per-slot occupancy flags; push and pop never target the same slot.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int i = 0; i < DEPTH; i++) begin
            valid_nxt_s[i] = (push_ok_s && (tail_r == PTR_W'(i))) ? 1'b1 :
                             (pop_ok_s  && (head_r == PTR_W'(i))) ? 1'b0 : valid_r[i];
        end
    end

    // Pointer, occupancy and slot-valid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {(PTR_W+1){1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            if (push_ok_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[tail_r] <= '{addr: push_addr, data: push_data};
        end
    end

    // Pending mask reflects only occupied slots, i.e. state before this cycle's push.
    always_comb begin
        pending_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pending_s = pending_s | (valid_r[i] ? reg_onehot(mem_r[i].addr) : {NUM_REGS{1'b0}});
        end
    end

    assign head_addr = mem_r[head_r].addr;
    assign head_data = mem_r[head_r].data;
    assign count     = count_r;
    assign pending   = pending_s;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port initiator: ALU results take priority, loads wait in a FIFO,
// same-register ordering is preserved and load starvation is bounded.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [4:0]              alu_addr,
    input  logic [31:0]             alu_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [4:0]              ld_addr,
    input  logic [31:0]             ld_data,
    output logic [4:0]              write_address,
    output logic [31:0]             write_data,
    output logic                    write_enable,
    output logic [31:0]             pending,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      fifo_count_s;
    logic [NUM_REGS-1:0]   pending_s;
    logic [REG_ADDR_W-1:0] head_addr_s;
    logic [XLEN-1:0]       head_data_s;
    logic                  fifo_nonempty_s;
    logic                  push_s;
    logic                  grant_alu_s;
    logic                  grant_fifo_s;
    logic                  alu_ready_s;
    logic [REG_ADDR_W-1:0] sel_addr_s;
    logic [XLEN-1:0]       sel_data_s;
    logic [STV_W-1:0]      starve_r;
    logic [STV_W-1:0]      starve_nxt_s;
    logic [REG_ADDR_W-1:0] wr_addr_r;
    logic [XLEN-1:0]       wr_data_r;
    logic                  wr_en_r;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_addr (ld_addr),
        .push_data (ld_data),
        .pop       (grant_fifo_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .count     (fifo_count_s),
        .pending   (pending_s)
    );

    assign fifo_nonempty_s = (fifo_count_s != {CNT_W{1'b0}});
    assign ld_ready        = !rst && (fifo_count_s < DEPTH_C);
    assign push_s          = ld_valid && ld_ready;

    // Arbitration: starvation cap or an older load to the same register overrides ALU priority.
    always_comb begin
        grant_alu_s  = 1'b0;
        grant_fifo_s = 1'b0;
        alu_ready_s  = 1'b0;
        if (rst) begin
            grant_fifo_s = 1'b0;
        end else if (fifo_nonempty_s &&
                     ((starve_r == STARVE_C) || (alu_valid && pending_s[alu_addr]))) begin
            grant_fifo_s = 1'b1;
        end else if (alu_valid) begin
            grant_alu_s = 1'b1;
            alu_ready_s = 1'b1;
        end else if (fifo_nonempty_s) begin
            grant_fifo_s = 1'b1;
        end else begin
            grant_fifo_s = 1'b0;
        end
    end

    assign alu_ready  = alu_ready_s;
    assign sel_addr_s = grant_fifo_s ? head_addr_s : alu_addr;
    assign sel_data_s = grant_fifo_s ? head_data_s : alu_data;

    // Starve count only advances while a load is actually waiting.
    always_comb begin
        starve_nxt_s = {STV_W{1'b0}};
        if (grant_alu_s && fifo_nonempty_s) begin
            starve_nxt_s = (starve_r == STARVE_C) ? starve_r : starve_r + STV_W'(1);
        end else begin
            starve_nxt_s = {STV_W{1'b0}};
        end
    end

    // Write-port register; r0 writes are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_r <= {REG_ADDR_W{1'b0}};
            wr_data_r <= {XLEN{1'b0}};
            wr_en_r   <= 1'b0;
            starve_r  <= {STV_W{1'b0}};
        end else begin
            starve_r <= starve_nxt_s;
            if (grant_alu_s || grant_fifo_s) begin
                wr_addr_r <= sel_addr_s;
                wr_data_r <= sel_data_s;
                wr_en_r   <= (sel_addr_s != {REG_ADDR_W{1'b0}});
            end else begin
                wr_en_r   <= 1'b0;
            end
        end
    end

    assign write_address = wr_addr_r;
    assign write_data    = wr_data_r;
    assign write_enable  = wr_en_r;
    assign pending       = pending_s;
    assign fifo_count    = fifo_count_s;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a queue-based reference model predicts
// grants and pushes expected writes (with due cycle) to a scoreboard; directed tasks add targeted checks.
module tb_regfile_writeback;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_addr = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_addr = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    exp_t        sb_q[$];
    ent_t        mq[$];
    int          m_starve = 0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] rf_model [32];

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .pending       (pending),
        .fifo_count    (fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ldd);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
    endtask

    // Reference model + scoreboard, evaluated mid-cycle on stable inputs.
    task automatic model_loop();
        exp_t        e;
        ent_t        h;
        logic [31:0] pm;
        logic        g_alu, g_fifo, exp_ld_rdy;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                n_checks++;
                if (write_enable !== 1'b1 || write_address !== e.addr || write_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_write cyc=%0d: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                             cyc, write_enable, write_address, write_data, e.addr, e.data);
                end
            end else begin
                n_checks++;
                if (write_enable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_idle cyc=%0d: got we=%b addr=%0d, expected we=0", cyc, write_enable, write_address);
                end
            end
            if (write_enable === 1'b1) rf_model[write_address] = write_data;

            pm = 32'd0;
            foreach (mq[i]) pm[mq[i].addr] = 1'b1;
            n_checks++;
            if (fifo_count !== 3'(mq.size()) || pending !== pm) begin
                n_fail++;
                $display("FAIL sb_state cyc=%0d: got count=%0d pending=%h, expected count=%0d pending=%h",
                         cyc, fifo_count, pending, mq.size(), pm);
            end

            g_alu = 1'b0; g_fifo = 1'b0;
            if (rst) begin
                g_alu = 1'b0;
            end else if (mq.size() > 0 && (m_starve == STARVE_LIMIT || (alu_valid && pm[alu_addr]))) begin
                g_fifo = 1'b1;
            end else if (alu_valid) begin
                g_alu = 1'b1;
            end else if (mq.size() > 0) begin
                g_fifo = 1'b1;
            end
            exp_ld_rdy = !rst && (mq.size() < DEPTH);
            n_checks++;
            if (alu_ready !== g_alu || ld_ready !== exp_ld_rdy) begin
                n_fail++;
                $display("FAIL sb_ready cyc=%0d: got alu_ready=%b ld_ready=%b, expected %b %b",
                         cyc, alu_ready, ld_ready, g_alu, exp_ld_rdy);
            end

            if (rst) begin
                mq.delete();
                m_starve = 0;
            end else begin
                if (g_alu) begin
                    if (alu_addr != 5'd0) sb_q.push_back('{cyc + 1, alu_addr, alu_data});
                    m_starve = (mq.size() > 0) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
                end else begin
                    m_starve = 0;
                end
                if (g_fifo) begin
                    h = mq.pop_front();
                    if (h.addr != 5'd0) sb_q.push_back('{cyc + 1, h.addr, h.data});
                end
                if (ld_valid && exp_ld_rdy) mq.push_back('{ld_addr, ld_data});
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready: got alu_ready=%b ld_ready=%b, expected 0 0", alu_ready, ld_ready);
            end
        end
        n_checks++;
        if (write_enable !== 1'b0 || write_address !== 5'd0 || write_data !== 32'd0 ||
            pending !== 32'd0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h pending=%h count=%0d, expected all 0",
                     write_enable, write_address, write_data, pending, fifo_count);
        end
        step();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_alu_only();
        step();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        step();
        drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd5 || write_data !== 32'hDEAD_BEEF || alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_write: got we=%b addr=%0d data=%h r0_ready=%b, expected 1 5 deadbeef 1",
                     write_enable, write_address, write_data, alu_ready);
        end
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_r0: got we=%b, expected 0", write_enable);
        end
    endtask

    task automatic test_fifo_full();
        logic [4:0] got[$];
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, 5'(10 + i), 32'hA000_0000 + i, 1'b1, 5'(1 + i), 32'h1000_0001 + i);
        end
        step();
        drive(1'b1, 5'd14, 32'hA000_0004, 1'b1, 5'd9, 32'h1000_0009);
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd4 || ld_ready !== 1'b0 || alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got count=%0d ld_ready=%b alu_ready=%b, expected 4 0 0",
                     fifo_count, ld_ready, alu_ready);
        end
        for (int j = 0; j < 20; j++) begin
            step();
            if (j < 6) drive(1'b1, 5'(16 + j), 32'hA000_0010 + j, 1'b0, 5'd0, 32'd0);
            else       drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            if (j == 0) begin
                n_checks++;
                if (write_enable !== 1'b1 || write_address !== 5'd1) begin
                    n_fail++;
                    $display("FAIL full_first_load: got we=%b addr=%0d, expected 1 1", write_enable, write_address);
                end
            end
            if (write_enable === 1'b1 && write_data[31:28] === 4'h1) got.push_back(write_address);
        end
        n_checks++;
        if (got.size() != 4 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3 || got[3] !== 5'd4) begin
            n_fail++;
            $display("FAIL full_drain_order: got %0d loads (first %0d), expected 1,2,3,4",
                     got.size(), (got.size() > 0) ? got[0] : 5'd0);
        end
    endtask

    task automatic test_waw();
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1000_0077);
        step();
        drive(1'b1, 5'd7, 32'hA000_0777, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (alu_ready !== 1'b0 || pending !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL waw_block: got alu_ready=%b pending=%h, expected 0 00000080", alu_ready, pending);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd7 || write_data !== 32'h1000_0077 || alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_load_first: got we=%b addr=%0d data=%h alu_ready=%b, expected 1 7 10000077 1",
                     write_enable, write_address, write_data, alu_ready);
        end
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (write_enable !== 1'b1 || write_address !== 5'd7 || write_data !== 32'hA000_0777) begin
            n_fail++;
            $display("FAIL waw_alu_second: got we=%b addr=%0d data=%h, expected 1 7 a0000777",
                     write_enable, write_address, write_data);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (rf_model[7] !== 32'hA000_0777) begin
            n_fail++;
            $display("FAIL waw_final_r7: got %h, expected a0000777", rf_model[7]);
        end
    endtask

    task automatic test_stream();
        int writes = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (i < 10) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + i), 32'h1000_0100 + i);
            else        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            n_checks++;
            if (fifo_count > 3'd1) begin
                n_fail++;
                $display("FAIL stream_count: got %0d, expected <= 1", fifo_count);
            end
            if (write_enable === 1'b1) writes++;
        end
        n_checks++;
        if (writes != 10) begin
            n_fail++;
            $display("FAIL stream_writes: got %0d, expected 10", writes);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            step();
            drive(1'b1, 5'((i * 3) % 8), 32'hB000_0000 + i, (i % 3) == 0, 5'(20 + i), 32'h1000_0200 + i);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step();
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b1, 5'(20 + i), 32'hA000_0020 + i, 1'b1, 5'(1 + i), 32'h1000_0301 + i);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd3 || pending !== 32'h0000_000E) begin
            n_fail++;
            $display("FAIL mreset_before: got count=%0d pending=%h, expected 3 0000000e", fifo_count, pending);
        end
        step();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++;
        if (write_enable !== 1'b0 || pending !== 32'd0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL mreset_after: got we=%b pending=%h count=%0d, expected 0 0 0",
                     write_enable, pending, fifo_count);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            n_checks++;
            if (write_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL mreset_quiet: got we=%b, expected 0", write_enable);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;
        fork
            model_loop();
        join_none
        test_reset();
        test_alu_only();
        test_fifo_full();
        test_waw();
        test_stream();
        test_back_to_back();
        test_random();
        test_mid_reset();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding writes, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the 32×32 register file: merges results from the ALU (unbuffered, priority) and the load unit (buffered in a small FIFO) onto the file's single write port. Provides a registered write_address/write_data/write_enable triple, enforces write-after-write ordering between the two sources, bounds load starvation, and exports a pending-write mask for hazard detection. Sits between execute/memory stages and the register file, in the same clock domain.

## Interface
- DEPTH, 4: load FIFO entries; power of 2, ≥2.
- STARVE_LIMIT, 3: max consecutive ALU grants while the FIFO is non-empty.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle (combinational).
- alu_addr  in  5  destination register.
- alu_data  in  32  result value.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  FIFO can accept (combinational).
- ld_addr  in  5  destination register.
- ld_data  in  32  loaded value.
- write_address  out  5  to register file write port (registered).
- write_data  out  32  to register file (registered).
- write_enable  out  1  to register file (registered).
- pending  out  32  bit r set iff a FIFO entry targets register r.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Enqueue: ld_valid && ld_ready pushes {ld_addr, ld_data} at tail. ld_ready = !rst && count < DEPTH; no pass-through when full, even if a dequeue occurs that cycle.
- Arbitration, at most one grant per cycle, evaluated in order:
  - rst high: no grant, alu_ready = 0.
  - FIFO non-empty and (starve == STARVE_LIMIT or pending[alu_addr] with alu_valid): grant FIFO head, alu_ready = 0.
  - alu_valid: grant ALU, alu_ready = 1.
  - FIFO non-empty: grant FIFO head.
- pending is computed from FIFO contents before this cycle's enqueue. ALU grant and same-address load enqueue in the same cycle: ALU is older, load write lands later.
- Starve counter: +1 on ALU grant while FIFO non-empty (saturates at STARVE_LIMIT); cleared on FIFO grant or whenever FIFO is empty.
- Granted request registers onto the write outputs next edge; write_enable = 1 except when granted address is 0: consumed (FIFO pops / ALU handshakes) but write_enable = 0.
- No grant: write_enable = 0, write_address/write_data hold previous values.
- Simultaneous enqueue and dequeue: count unchanged, pointers both advance, wrap modulo DEPTH.

## Timing
- Reset values: write_enable 0, write_address 0, write_data 0, count 0, head/tail 0, starve 0, pending 0; ld_ready and alu_ready 0 while rst is high.
- Reset mid-operation discards all FIFO contents; no write is emitted for them.
- ALU latency: accept at edge t → write_enable high in cycle t+1 → file commits at edge t+1.
- Load latency: enqueue at edge t → earliest grant cycle t+1 → write_enable cycle t+2.
- Throughput: one register write per cycle sustained.
- alu_ready depends combinationally on alu_valid, alu_addr and state; ld_ready on state only.

## Structure
- Package regfile_pkg: XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32, struct wb_req_t {addr, data}; shared with the register file and decode.
- Sub-module wb_fifo: circular buffer of wb_req_t with head/tail/count, push/pop, head output and pending-mask generation. Arbiter, starve counter and output register stay in the top level.

## Test plan
- Reset: hold rst 3 cycles with both valids high → write_enable 0, both readies 0, pending 0, fifo_count 0.
- ALU only: alu_addr 5, data 0xDEADBEEF at edge t → write_enable=1, write_address=5, write_data=0xDEADBEEF in cycle t+1; alu_addr 0 → alu_ready 1, write_enable 0.
- FIFO full: push 4 loads (addrs 1–4) with alu_valid held on non-conflicting addrs → ld_ready 0 at count 4; after 3 ALU grants the 4th cycle grants FIFO (addr 1); loads drain in order 1,2,3,4.
- WAW: FIFO holds load to r7, ALU offers r7 → alu_ready 0 until r7 entry written, then ALU write to r7 lands one cycle after it; final r7 = ALU value.
- Wrap and simultaneous push/pop: stream 10 loads at full rate with no ALU traffic → fifo_count stays ≤1, writes emitted in order with 2-cycle latency.
- Mid-operation reset with 3 queued loads → no further write_enable, pending 0, fifo_count 0 the cycle after reset.
